// File: rtl/dcache_wt_if.sv
// Signal bundle between the memory stage, the write-through data cache and
// the memory arbiter. The slave modport is the cache's view; the master
// modport is the surrounding datapath/arbiter view.
//
// Handshake: a datapath request (dmemREN or dmemWEN) is held stable until the
// cycle in which dhit is high; that cycle completes the request. On the memory
// side, dREN/dWEN are held with daddr/dstore until a cycle with dwait=0, and
// the access completes at that rising edge (dload is valid in that cycle).
interface dcache_wt_if;
    // datapath side
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic [31:0] hit_count;
    // memory side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, hit_count, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, hit_count, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Read hits complete combinationally; read misses fill one line from
// memory; every store goes to memory and updates the line only on a hit.
// After halt the cache parks in HALTED and raises flushed.
module dcache_wt #(
    parameter int SETS = 16
) (
    input  logic       CLK,
    input  logic       nRST,
    dcache_wt_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        WRITE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tag_arr  [SETS];
    logic [31:0]     data_arr [SETS];
    logic [31:0]     hit_cnt;

    logic [IW-1:0]   index;
    logic [TW-1:0]   tag;
    logic            hit;
    logic            fill_we;
    logic            store_we;
    logic            cnt_inc;

    // byte offset is always zero for word accesses
    logic unused_offset;
    assign unused_offset = ^bus.dmemaddr[1:0];

    assign index = bus.dmemaddr[IW+1:2];
    assign tag   = bus.dmemaddr[31:IW+2];
    assign hit   = valid[index] && (tag_arr[index] == tag);

    assign bus.hit_count = hit_cnt;
    assign dbg_state     = state;

    // state register; reset returns to IDLE from any state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // next-state and all outputs; memory outputs stay 0 outside FILL/WRITE
    always_comb begin
        next_state   = state;
        bus.dhit     = 1'b0;
        bus.dmemload = 32'd0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        fill_we      = 1'b0;
        store_we     = 1'b0;
        cnt_inc      = 1'b0;
        unique case (state)
            IDLE: begin
                // stores win over loads; halt only when no request is pending
                if (bus.dmemWEN) begin
                    next_state = WRITE;
                end else if (bus.dmemREN) begin
                    if (hit) begin
                        bus.dhit     = 1'b1;
                        bus.dmemload = data_arr[index];
                        cnt_inc      = 1'b1;
                    end else begin
                        next_state = FILL;
                    end
                end else if (bus.halt) begin
                    next_state = HALTED;
                end
            end
            FILL: begin
                bus.dREN  = 1'b1;
                bus.daddr = bus.dmemaddr;
                if (!bus.dwait) begin
                    fill_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = bus.dmemaddr;
                bus.dstore = bus.dmemstore;
                if (!bus.dwait) begin
                    bus.dhit   = 1'b1;
                    next_state = IDLE;
                    if (hit) begin
                        store_we = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                end
            end
            HALTED: begin
                bus.flushed = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // valid bits are the only array state that reset must clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        valid        <= '0;
        else if (fill_we) valid[index] <= 1'b1;
    end

    // tag/data arrays: fill writes tag and data, a store hit writes data only
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= bus.dload;
        end else if (store_we) begin
            data_arr[index] <= bus.dmemstore;
        end
    end

    // hit counter counts read hits and write hits, wrapping
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        hit_cnt <= 32'd0;
        else if (cnt_inc) hit_cnt <= hit_cnt + 32'd1;
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Directed testbench for dcache_wt (SETS=16). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge, or 1 unit after
// the rising edge for registered counters.
module tb_dcache_wt;
    logic       CLK;
    logic       nRST;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    dcache_wt_if bus ();

    dcache_wt #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.dmemREN   = r;
        bus.dmemWEN   = w;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
    endtask

    initial begin
        nRST = 1'b0;
        req(1'b0, 1'b0, 32'd0, 32'd0);
        bus.halt  = 1'b0;
        bus.dload = 32'd0;
        bus.dwait = 1'b1;

        // reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dhit", bus.dhit, 32'd0);
        chk("rst_dren", bus.dREN, 32'd0);
        chk("rst_dwen", bus.dWEN, 32'd0);
        chk("rst_flushed", bus.flushed, 32'd0);
        chk("rst_hitcnt", bus.hit_count, 32'd0);
        chk("rst_state", dbg_state, 32'd0);
        cyc();
        nRST = 1'b1;

        // read miss on 0x40, memory busy for 3 FILL cycles
        req(1'b1, 1'b0, 32'h40, 32'd0);
        bus.dwait = 1'b1;
        bus.dload = 32'hDEADBEEF;
        @(negedge CLK);
        chk("miss_req_dhit", bus.dhit, 32'd0);
        chk("miss_req_dren", bus.dREN, 32'd0);
        chk("miss_req_load", bus.dmemload, 32'd0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("fill_wait_dren", bus.dREN, 32'd1);
            chk("fill_wait_daddr", bus.daddr, 32'h40);
            chk("fill_wait_dhit", bus.dhit, 32'd0);
            cyc();
        end
        bus.dwait = 1'b0;
        @(negedge CLK);
        chk("fill_done_dren", bus.dREN, 32'd1);
        chk("fill_done_dhit", bus.dhit, 32'd0);
        cyc();
        @(negedge CLK);
        chk("after_fill_dhit", bus.dhit, 32'd1);
        chk("after_fill_load", bus.dmemload, 32'hDEADBEEF);
        chk("after_fill_dren", bus.dREN, 32'd0);
        cyc();
        chk("hitcnt_1", bus.hit_count, 32'd1);

        // read hit on 0x40: zero latency
        bus.dload = 32'h0;
        @(negedge CLK);
        chk("rhit_dhit", bus.dhit, 32'd1);
        chk("rhit_load", bus.dmemload, 32'hDEADBEEF);
        chk("rhit_dren", bus.dREN, 32'd0);
        cyc();
        chk("hitcnt_2", bus.hit_count, 32'd2);

        // write hit to 0x40, memory ready immediately
        req(1'b0, 1'b1, 32'h40, 32'h12345678);
        @(negedge CLK);
        chk("wr_req_dhit", bus.dhit, 32'd0);
        chk("wr_req_dwen", bus.dWEN, 32'd0);
        cyc();
        @(negedge CLK);
        chk("wr_dwen", bus.dWEN, 32'd1);
        chk("wr_dstore", bus.dstore, 32'h12345678);
        chk("wr_daddr", bus.daddr, 32'h40);
        chk("wr_dhit", bus.dhit, 32'd1);
        chk("wr_load_zero", bus.dmemload, 32'd0);
        cyc();
        chk("hitcnt_3", bus.hit_count, 32'd3);
        req(1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge CLK);
        chk("rd_after_wr_dhit", bus.dhit, 32'd1);
        chk("rd_after_wr_load", bus.dmemload, 32'h12345678);
        cyc();
        chk("hitcnt_4", bus.hit_count, 32'd4);

        // conflict: 0x440 shares index 0 with 0x40
        req(1'b1, 1'b0, 32'h440, 32'd0);
        bus.dload = 32'hCAFEF00D;
        @(negedge CLK);
        chk("conf_miss_dhit", bus.dhit, 32'd0);
        cyc();
        @(negedge CLK);
        chk("conf_fill_dren", bus.dREN, 32'd1);
        chk("conf_fill_daddr", bus.daddr, 32'h440);
        cyc();
        @(negedge CLK);
        chk("conf_hit_load", bus.dmemload, 32'hCAFEF00D);
        cyc();
        chk("hitcnt_5", bus.hit_count, 32'd5);
        req(1'b1, 1'b0, 32'h40, 32'd0);
        bus.dload = 32'h12345678;
        @(negedge CLK);
        chk("evicted_miss_dhit", bus.dhit, 32'd0);
        cyc();
        @(negedge CLK);
        chk("evicted_fill_dren", bus.dREN, 32'd1);
        chk("evicted_fill_daddr", bus.daddr, 32'h40);
        cyc();
        @(negedge CLK);
        chk("refill_load", bus.dmemload, 32'h12345678);
        cyc();
        chk("hitcnt_6", bus.hit_count, 32'd6);

        // write miss to 0x80, memory busy one cycle
        req(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5);
        bus.dwait = 1'b1;
        cyc();
        @(negedge CLK);
        chk("wmiss_busy_dwen", bus.dWEN, 32'd1);
        chk("wmiss_busy_dhit", bus.dhit, 32'd0);
        cyc();
        bus.dwait = 1'b0;
        @(negedge CLK);
        chk("wmiss_dhit", bus.dhit, 32'd1);
        chk("wmiss_dstore", bus.dstore, 32'hA5A5A5A5);
        cyc();
        chk("hitcnt_wmiss", bus.hit_count, 32'd6);
        req(1'b1, 1'b0, 32'h80, 32'd0);
        bus.dload = 32'hA5A5A5A5;
        @(negedge CLK);
        chk("no_alloc_dhit", bus.dhit, 32'd0);
        cyc();
        @(negedge CLK);
        chk("no_alloc_dren", bus.dREN, 32'd1);
        chk("no_alloc_daddr", bus.daddr, 32'h80);
        cyc();
        @(negedge CLK);
        chk("no_alloc_load", bus.dmemload, 32'hA5A5A5A5);
        cyc();
        chk("hitcnt_7", bus.hit_count, 32'd7);

        // halt raised during a fill of 0x100
        req(1'b1, 1'b0, 32'h100, 32'd0);
        bus.dload = 32'h0BADF00D;
        bus.dwait = 1'b1;
        cyc();
        bus.halt = 1'b1;
        @(negedge CLK);
        chk("halt_fill_dren", bus.dREN, 32'd1);
        chk("halt_fill_state", dbg_state, 32'd1);
        cyc();
        bus.dwait = 1'b0;
        cyc();
        @(negedge CLK);
        chk("halt_hit_dhit", bus.dhit, 32'd1);
        chk("halt_hit_load", bus.dmemload, 32'h0BADF00D);
        cyc();
        chk("hitcnt_8", bus.hit_count, 32'd8);
        req(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge CLK);
        chk("halt_idle_flushed", bus.flushed, 32'd0);
        chk("halt_idle_state", dbg_state, 32'd0);
        cyc();
        @(negedge CLK);
        chk("halted_flushed", bus.flushed, 32'd1);
        chk("halted_state", dbg_state, 32'd3);
        req(1'b1, 1'b0, 32'h100, 32'd0);
        #1;
        chk("halted_dhit", bus.dhit, 32'd0);
        chk("halted_dren", bus.dREN, 32'd0);
        cyc();
        @(negedge CLK);
        chk("halted_sticky", bus.flushed, 32'd1);

        // reset out of HALTED, then reset while a fill is in flight
        cyc();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        bus.halt = 1'b0;
        bus.dwait = 1'b1;
        req(1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge CLK);
        chk("post_rst_miss", bus.dhit, 32'd0);
        chk("post_rst_flushed", bus.flushed, 32'd0);
        cyc();
        @(negedge CLK);
        chk("midfill_dren", bus.dREN, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst_dren", bus.dREN, 32'd0);
        chk("async_rst_state", dbg_state, 32'd0);
        chk("async_rst_hitcnt", bus.hit_count, 32'd0);
        cyc();
        nRST = 1'b1;
        req(1'b1, 1'b0, 32'h100, 32'd0);
        @(negedge CLK);
        chk("invalidated_miss", bus.dhit, 32'd0);
        cyc();
        @(negedge CLK);
        chk("invalidated_fill_dren", bus.dREN, 32'd1);
        chk("invalidated_fill_daddr", bus.daddr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
